// File: rtl/count_rx_checker.sv
// count_rx_checker: receives the free-running count pattern on the PMOD pins,
// resynchronises and debounces it, and checks each newly accepted value for
// a +1 (mod 2^WIDTH) step from the previous one.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   pmod_in      raw pattern pins, asynchronous to clk
//   last_value   most recently accepted value
//   value_valid  one-cycle pulse when last_value updates
//   locked       LOCK_COUNT consecutive good steps seen, no error/stall since
//   err_pulse    one-cycle pulse on a bad step
//   err_count    saturating count of bad steps
//   stall        no accepted value for TIMEOUT clocks
module count_rx_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STABLE     = 2,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pmod_in,
  output logic [WIDTH-1:0] last_value,
  output logic             value_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic             stall
);

  // Run counter saturates one above STABLE so acceptance fires once per run.
  localparam int unsigned CW = $clog2(STABLE + 2);
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_STALL  = 2'd3
  } state_e;

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [CW-1:0]    run_q;
  logic [CW-1:0]    run_d;
  state_e           state_q;
  logic [GW-1:0]    good_run_q;
  logic [GW-1:0]    good_run_inc;
  logic [TW-1:0]    timer_q;
  logic [TW-1:0]    timer_inc;
  logic [WIDTH-1:0] last_value_q;
  logic             value_valid_q;
  logic             err_pulse_q;
  logic             locked_q;
  logic             stall_q;
  logic [15:0]      err_count_q;
  logic             fire;
  logic             accept;
  logic             good_step;

  // Two-flop synchroniser; data flops carry no reset.
  always_ff @(posedge clk) begin
    meta_q <= pmod_in;
    sync_q <= meta_q;
  end

  // Stability filter, acceptance qualification and saturating increments.
  always_comb begin
    run_d = CW'(1);
    if (sync_q == prev_q) begin
      if (run_q < CW'(STABLE)) begin
        run_d = run_q + CW'(1);
      end else begin
        run_d = CW'(STABLE + 1);
      end
    end
    fire   = (run_d == CW'(STABLE));
    // Once tracking, a re-stabilised copy of the current value is not news.
    accept = fire && ((state_q == ST_IDLE) || (state_q == ST_STALL) ||
                      (sync_q != last_value_q));
    good_step    = (sync_q == WIDTH'(last_value_q + WIDTH'(1)));
    good_run_inc = (good_run_q == GW'(LOCK_COUNT)) ? good_run_q
                                                   : good_run_q + GW'(1);
    timer_inc    = timer_q + TW'(1);
  end

  // Checker state machine with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q        <= '0;
      run_q         <= '0;
      state_q       <= ST_IDLE;
      good_run_q    <= '0;
      timer_q       <= '0;
      last_value_q  <= '0;
      value_valid_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      locked_q      <= 1'b0;
      stall_q       <= 1'b0;
      err_count_q   <= '0;
    end else begin
      prev_q        <= sync_q;
      run_q         <= run_d;
      value_valid_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      if (accept) begin
        // Acceptance beats a coincident timeout.
        last_value_q  <= sync_q;
        value_valid_q <= 1'b1;
        timer_q       <= '0;
        case (state_q)
          ST_IDLE, ST_STALL: begin
            state_q    <= ST_TRACK;
            good_run_q <= '0;
            locked_q   <= 1'b0;
            stall_q    <= 1'b0;
          end
          default: begin
            if (good_step) begin
              good_run_q <= good_run_inc;
              if (good_run_inc == GW'(LOCK_COUNT)) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              state_q     <= ST_TRACK;
              locked_q    <= 1'b0;
              good_run_q  <= '0;
              err_pulse_q <= 1'b1;
              if (err_count_q != 16'hFFFF) begin
                err_count_q <= err_count_q + 16'd1;
              end
            end
          end
        endcase
      end else if ((state_q == ST_TRACK) || (state_q == ST_LOCKED)) begin
        if (timer_inc == TW'(TIMEOUT)) begin
          state_q    <= ST_STALL;
          stall_q    <= 1'b1;
          locked_q   <= 1'b0;
          good_run_q <= '0;
          timer_q    <= '0;
        end else begin
          timer_q <= timer_inc;
        end
      end
    end
  end

  assign last_value  = last_value_q;
  assign value_valid = value_valid_q;
  assign err_pulse   = err_pulse_q;
  assign locked      = locked_q;
  assign stall       = stall_q;
  assign err_count   = err_count_q;

endmodule
